// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the EX stage: issues to external mul/div cores,
// owns the architectural HI/LO registers and stalls EX while an operation is in flight.
module md_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_fire,
  input  logic        flush,
  output logic        stallreq,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic is_mul, is_div, is_mthi, is_mtlo;

  assign is_mul  = op_valid & ((op == 3'd1) | (op == 3'd2));
  assign is_div  = op_valid & ((op == 3'd3) | (op == 3'd4));
  assign is_mthi = op_valid & (op == 3'd5);
  assign is_mtlo = op_valid & (op == 3'd6);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // flush overrides every completion path so a killed op never reaches HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
          end else if (is_div) begin
            state_d = S_DIV;
          end else if (is_mthi) begin
            hi_d = src1;
          end else if (is_mtlo) begin
            lo_d = src1;
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            hi_d    = mul_result[63:32];
            lo_d    = mul_result[31:0];
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (div_ready) begin
            hi_d    = div_result[63:32];
            lo_d    = div_result[31:0];
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // The op is still held in EX here; wait for it to leave rather than reissue.
          if (ex_fire) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq    = 1'b0;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    div_annul   = 1'b0;
    if (resetn) begin
      case (state_q)
        S_IDLE: stallreq = (is_mul | is_div) & ~flush;
        S_MUL: begin
          stallreq   = ~flush;
          mul_ina    = src1;
          mul_inb    = src2;
          mul_signed = (op == 3'd1);
        end
        S_DIV: begin
          // Result is written on the div_ready edge, so EX may advance that same cycle.
          stallreq    = ~div_ready & ~flush;
          div_start   = ~flush;
          div_annul   = flush;
          div_opdata1 = src1;
          div_opdata2 = src2;
          div_signed  = (op == 3'd3);
        end
        default: ;
      endcase
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: drives inputs on the falling edge and checks
// outputs 1ns later against hand-computed values.
module tb_md_ctrl;
  localparam int MUL_CYCLES = 5;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3;

  logic        clk, resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        ex_fire, flush;
  logic        stallreq;
  logic [31:0] hi_o, lo_o;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed;
  logic [31:0] div_opdata1, div_opdata2;
  logic        div_annul, div_ready;
  logic [63:0] div_result;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  md_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .src1(src1), .src2(src2), .ex_fire(ex_fire), .flush(flush),
    .stallreq(stallreq), .hi_o(hi_o), .lo_o(lo_o),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_opdata1(div_opdata1),
    .div_opdata2(div_opdata2), .div_annul(div_annul), .div_ready(div_ready),
    .div_result(div_result), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    op_valid = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    ex_fire = 1'b0; flush = 1'b0; div_ready = 1'b0;
    div_result = '0; mul_result = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    op_valid = 1'b1; op = 3'd1; src1 = 32'h1; src2 = 32'h2;
    @(negedge clk); #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stallreq); end
    n_vec++; if (mul_ina !== 32'h0) begin n_err++; $display("FAIL reset_mul_ina got %h want 0", mul_ina); end
    @(negedge clk); #1;
    n_vec++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    op_valid = 1'b1; op = 3'd1; src1 = 32'hFFFFFFFD; src2 = 32'h00000005;
    mul_result = 64'hFFFFFFFF_FFFFFFF1;
    #1;
    n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL mult_issue_stall got %b want 1", stallreq); end
    for (int i = 0; i < MUL_CYCLES; i++) begin
      @(negedge clk); #1;
      n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL mult_stall[%0d] got %b want 1", i, stallreq); end
      n_vec++; if (mul_ina !== 32'hFFFFFFFD || mul_inb !== 32'h5 || mul_signed !== 1'b1) begin
        n_err++; $display("FAIL mult_operands[%0d] got %h %h s%b want fffffffd 00000005 s1", i, mul_ina, mul_inb, mul_signed);
      end
    end
    @(negedge clk); #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL mult_done_stall got %b want 0", stallreq); end
    n_vec++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_hilo got %h/%h want ffffffff/fffffff1", hi_o, lo_o); end
    n_vec++; if (mul_ina !== 32'h0) begin n_err++; $display("FAIL mult_done_ina got %h want 0", mul_ina); end
    ex_fire = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mult_back_idle got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_divu();
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; src1 = 32'd100; src2 = 32'd7;
    #1;
    n_vec++; if (stallreq !== 1'b1 || div_start !== 1'b0) begin n_err++; $display("FAIL divu_issue got stall%b start%b want stall1 start0", stallreq, div_start); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++; if (div_start !== 1'b1 || stallreq !== 1'b1) begin n_err++; $display("FAIL divu_wait[%0d] got start%b stall%b want 1 1", i, div_start, stallreq); end
      n_vec++; if (div_opdata1 !== 32'd100 || div_opdata2 !== 32'd7 || div_signed !== 1'b0) begin
        n_err++; $display("FAIL divu_operands[%0d] got %h %h s%b want 00000064 00000007 s0", i, div_opdata1, div_opdata2, div_signed);
      end
    end
    @(negedge clk);
    div_ready = 1'b1; div_result = {32'd2, 32'd14};
    #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL divu_ready_stall got %b want 0", stallreq); end
    @(negedge clk);
    div_ready = 1'b0; div_result = '0;
    #1;
    n_vec++; if (hi_o !== 32'd2 || lo_o !== 32'd14) begin n_err++; $display("FAIL divu_hilo got %h/%h want 00000002/0000000e", hi_o, lo_o); end
    n_vec++; if (div_start !== 1'b0 || stallreq !== 1'b0) begin n_err++; $display("FAIL divu_done got start%b stall%b want 0 0", div_start, stallreq); end
    ex_fire = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_div_hold();
    @(negedge clk);
    op_valid = 1'b1; op = 3'd3; src1 = 32'hFFFFFFF9; src2 = 32'd2;
    @(negedge clk); #1;
    n_vec++; if (div_signed !== 1'b1 || div_start !== 1'b1) begin n_err++; $display("FAIL div_signed got s%b start%b want s1 start1", div_signed, div_start); end
    @(negedge clk);
    div_ready = 1'b1; div_result = {32'hFFFFFFFF, 32'hFFFFFFFD};
    @(negedge clk);
    div_ready = 1'b0; div_result = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (stallreq !== 1'b0 || div_start !== 1'b0 || dbg_state !== ST_DONE) begin
        n_err++; $display("FAIL div_hold[%0d] got stall%b start%b st%0d want 0 0 %0d", i, stallreq, div_start, dbg_state, ST_DONE);
      end
      @(negedge clk);
    end
    #1;
    n_vec++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_hilo got %h/%h want ffffffff/fffffffd", hi_o, lo_o); end
    ex_fire = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (dbg_state !== ST_IDLE || stallreq !== 1'b0) begin n_err++; $display("FAIL div_release got st%0d stall%b want %0d 0", dbg_state, stallreq, ST_IDLE); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    op_valid = 1'b1; op = 3'd5; src1 = 32'hDEADBEEF;
    #1;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL mthi_stall got %b want 0", stallreq); end
    @(negedge clk);
    op = 3'd6; src1 = 32'h12345678;
    #1;
    n_vec++; if (hi_o !== 32'hDEADBEEF || lo_o !== 32'hFFFFFFFD) begin n_err++; $display("FAIL mthi_visible got %h/%h want deadbeef/fffffffd", hi_o, lo_o); end
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL mtlo_stall got %b want 0", stallreq); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (hi_o !== 32'hDEADBEEF || lo_o !== 32'h12345678) begin n_err++; $display("FAIL mtlo_visible got %h/%h want deadbeef/12345678", hi_o, lo_o); end
  endtask

  task automatic test_flush_div();
    @(negedge clk);
    op_valid = 1'b1; op = 3'd3; src1 = 32'd50; src2 = 32'd5;
    for (int i = 0; i < 4; i++) @(negedge clk);
    flush = 1'b1; div_ready = 1'b1; div_result = 64'hAAAAAAAA_55555555;
    #1;
    n_vec++; if (div_annul !== 1'b1 || stallreq !== 1'b0 || div_start !== 1'b0) begin
      n_err++; $display("FAIL flush_pulse got annul%b stall%b start%b want 1 0 0", div_annul, stallreq, div_start);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (div_annul !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL flush_after got annul%b st%0d want 0 %0d", div_annul, dbg_state, ST_IDLE); end
    n_vec++; if (hi_o !== 32'hDEADBEEF || lo_o !== 32'h12345678) begin n_err++; $display("FAIL flush_hilo got %h/%h want deadbeef/12345678", hi_o, lo_o); end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    op_valid = 1'b1; op = 3'd2; src1 = 32'h3; src2 = 32'h4; mul_result = 64'hC;
    @(negedge clk); @(negedge clk);
    resetn = 1'b0;
    #1;
    n_vec++; if (stallreq !== 1'b0 || mul_ina !== 32'h0) begin n_err++; $display("FAIL rst_mul_outputs got stall%b ina%h want 0 0", stallreq, mul_ina); end
    @(negedge clk);
    resetn = 1'b1;
    idle_inputs();
    #1;
    n_vec++; if (hi_o !== 32'h0 || lo_o !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL rst_mul_state got %h/%h st%0d want 0/0 %0d", hi_o, lo_o, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    op_valid = 1'b1; op = 3'd2; src1 = 32'hFFFFFFFF; src2 = 32'h2; mul_result = 64'h00000001_FFFFFFFE;
    @(negedge clk); #1;
    n_vec++; if (mul_signed !== 1'b0 || stallreq !== 1'b1) begin n_err++; $display("FAIL multu_signed got s%b stall%b want s0 stall1", mul_signed, stallreq); end
    for (int i = 0; i < MUL_CYCLES; i++) @(negedge clk);
    #1;
    n_vec++; if (hi_o !== 32'h1 || lo_o !== 32'hFFFFFFFE || stallreq !== 1'b0) begin
      n_err++; $display("FAIL multu_hilo got %h/%h stall%b want 00000001/fffffffe stall0", hi_o, lo_o, stallreq);
    end
    ex_fire = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_div_hold();
    test_mthi_mtlo();
    test_flush_div();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
